// File: rtl/camera_capture.sv
// Camera parallel-bus capture: assembles RGB565 pixels from byte pairs and tags them with
// frame coordinates, reporting per-frame completion and geometry/integrity.
module camera_capture #(
    parameter logic [9:0] FRAME_WIDTH  = 10'd320,
    parameter logic [8:0] FRAME_HEIGHT = 9'd240
) (
    input  logic        pixel_clock_in,
    input  logic        rst_n_in,
    input  logic        vsync_in,
    input  logic        href_in,
    input  logic [7:0]  camera_data_in,
    output logic [9:0]  frame_x_count,
    output logic [8:0]  frame_y_count,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        frame_ok
);

    localparam logic [1:0] WAIT_VSYNC = 2'd0;
    localparam logic [1:0] VBLANK     = 2'd1;
    localparam logic [1:0] BYTE_HI    = 2'd2;
    localparam logic [1:0] BYTE_LO    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [9:0]  next_x_q, next_x_d;
    logic [8:0]  next_y_q, next_y_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic        href_q;
    logic        err_q, err_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [15:0] pix_q, pix_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        line_end;

    assign line_end      = href_q & ~href_in;
    assign frame_x_count = x_q;
    assign frame_y_count = y_q;
    assign pixel_data    = pix_q;
    assign pixel_valid   = valid_q;
    assign frame_done    = done_q;
    assign frame_ok      = ok_q;

    always_comb begin
        state_d   = state_q;
        next_x_d  = next_x_q;
        next_y_d  = next_y_q;
        hi_byte_d = hi_byte_q;
        err_d     = err_q;
        x_d       = x_q;
        y_d       = y_q;
        pix_d     = pix_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        ok_d      = 1'b0;
        case (state_q)
            WAIT_VSYNC: begin
                if (vsync_in) state_d = VBLANK;
            end
            VBLANK: begin
                next_x_d = '0;
                next_y_d = '0;
                err_d    = 1'b0;
                x_d      = '0;
                y_d      = '0;
                pix_d    = '0;
                if (!vsync_in) state_d = BYTE_HI;
            end
            default: begin
                // vsync takes priority over a coincident line end
                if (vsync_in) begin
                    state_d = VBLANK;
                    done_d  = 1'b1;
                    ok_d    = !err_q && (next_y_q == FRAME_HEIGHT) && (next_x_q == 10'd0);
                end else if (line_end) begin
                    if (state_q == BYTE_LO) err_d = 1'b1;
                    if (next_x_q != FRAME_WIDTH) err_d = 1'b1;
                    state_d  = BYTE_HI;
                    next_x_d = '0;
                    if (next_y_q == FRAME_HEIGHT) err_d = 1'b1;
                    else next_y_d = next_y_q + 9'd1;
                end else if (href_in) begin
                    if (state_q == BYTE_HI) begin
                        hi_byte_d = camera_data_in;
                        state_d   = BYTE_LO;
                    end else begin
                        state_d = BYTE_HI;
                        if (next_x_q < FRAME_WIDTH && next_y_q < FRAME_HEIGHT) begin
                            pix_d    = {hi_byte_q, camera_data_in};
                            valid_d  = 1'b1;
                            x_d      = next_x_q;
                            y_d      = next_y_q;
                            next_x_d = next_x_q + 10'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge pixel_clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= WAIT_VSYNC;
            next_x_q  <= '0;
            next_y_q  <= '0;
            hi_byte_q <= '0;
            href_q    <= 1'b0;
            err_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            pix_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            next_x_q  <= next_x_d;
            next_y_q  <= next_y_d;
            hi_byte_q <= hi_byte_d;
            href_q    <= href_in;
            err_q     <= err_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pix_q     <= pix_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
        end
    end

endmodule
